// File: rtl/game_frame_tx.sv
// UART frame transmitter for the board-to-board game link: snapshots N_FIELDS words on start
// and sends SYNC, the little-endian payload bytes and an XOR checksum as 8N1, LSB first.
module game_frame_tx #(
  parameter int         N_FIELDS  = 4,
  parameter int         FIELD_W   = 11,
  parameter int         CLK_HZ    = 65_000_000,
  parameter int         BAUD      = 115_200,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [N_FIELDS*FIELD_W-1:0]  fields,
  output logic                         tx,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         dropped
);

  localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int BPF   = (FIELD_W + 7) / 8;
  localparam int PAY_W = N_FIELDS * BPF * 8;
  localparam int LEN   = 2 + N_FIELDS * BPF;
  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW    = $clog2(LEN);

  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [7:0]       byte_q, byte_d;
  logic [PAY_W-1:0] pay_q, pay_d;
  logic [7:0]       chk_q, chk_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;

  logic [PAY_W-1:0] pad_vec;
  logic [IW-1:0]    idx_nxt;
  logic             baud_end;

  // Each field is zero-extended to a whole number of bytes, field 0 in the low bytes.
  always_comb begin
    pad_vec = '0;
    for (int k = 0; k < N_FIELDS; k++) begin
      pad_vec[k*BPF*8 +: FIELD_W] = fields[k*FIELD_W +: FIELD_W];
    end
  end

  assign baud_end = (baud_q == BAUD_LAST);
  assign idx_nxt  = idx_q + IW'(1);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    pay_d   = pay_q;
    chk_d   = chk_q;
    tx_d    = tx_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
        if (start) begin
          state_d = S_START;
          baud_d  = '0;
          bit_d   = '0;
          idx_d   = '0;
          byte_d  = SYNC_BYTE;
          pay_d   = pad_vec;
          chk_d   = '0;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = byte_q[0];
          byte_d  = byte_q >> 1;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d  = bit_q + 3'd1;
            tx_d   = byte_q[0];
            byte_d = byte_q >> 1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
            tx_d    = 1'b1;
          end else begin
            // Next start bit follows the stop bit directly; the checksum goes out last.
            state_d = S_START;
            idx_d   = idx_nxt;
            tx_d    = 1'b0;
            if (idx_nxt == IDX_LAST) begin
              byte_d = chk_q;
            end else begin
              byte_d = pay_q[7:0];
              pay_d  = pay_q >> 8;
              chk_d  = chk_q ^ pay_q[7:0];
            end
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    busy_d = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
    done_d = (state_d == S_DONE);
    drop_d = start && busy_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      pay_q   <= '0;
      chk_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      pay_q   <= pay_d;
      chk_q   <= chk_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign dropped    = drop_q;

endmodule

// File: tb/tb_game_frame_tx.sv
// Bench for game_frame_tx: a line receiver decodes tx into bytes, compared against frames
// built from the field values by a byte-level model; three parameterisations are exercised.
module tb_game_frame_tx;

  localparam int DIV = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, start_b, start_c;
  logic [21:0] fields_a;
  logic [19:0] fields_b;
  logic [31:0] fields_c;
  logic        tx_a, busy_a, done_a, drop_a;
  logic        tx_b, busy_b, done_b, drop_b;
  logic        tx_c, busy_c, done_c, drop_c;

  game_frame_tx #(.N_FIELDS(2), .FIELD_W(11), .CLK_HZ(16), .BAUD(1), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .fields(fields_a),
    .tx(tx_a), .busy(busy_a), .frame_done(done_a), .dropped(drop_a));

  game_frame_tx #(.N_FIELDS(5), .FIELD_W(4), .CLK_HZ(16), .BAUD(1), .SYNC_BYTE(8'hA5)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .fields(fields_b),
    .tx(tx_b), .busy(busy_b), .frame_done(done_b), .dropped(drop_b));

  game_frame_tx #(.N_FIELDS(2), .FIELD_W(16), .CLK_HZ(16), .BAUD(1), .SYNC_BYTE(8'hA5)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .fields(fields_c),
    .tx(tx_c), .busy(busy_c), .frame_done(done_c), .dropped(drop_c));

  int   sel;
  logic cur_tx, cur_busy, cur_done, cur_drop;

  always_comb begin
    case (sel)
      1:       begin cur_tx = tx_b; cur_busy = busy_b; cur_done = done_b; cur_drop = drop_b; end
      2:       begin cur_tx = tx_c; cur_busy = busy_c; cur_done = done_c; cur_drop = drop_c; end
      default: begin cur_tx = tx_a; cur_busy = busy_a; cur_done = done_a; cur_drop = drop_a; end
    endcase
  end

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         mvals[8];
  bit         mon_act;
  int         mon_cnt;
  logic [7:0] mon_sh;
  int         frame_err;
  int         n_chk, n_fail, drop_cnt, done_cnt;

  typedef struct {
    logic [10:0] f0;
    logic [10:0] f1;
    logic [7:0]  chk;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: advance to the falling edge, then count pulses and run the line receiver.
  task automatic step();
    int b;
    @(negedge clk);
    if (cur_drop === 1'b1) drop_cnt++;
    if (cur_done === 1'b1) done_cnt++;
    if (!rst_n) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (cur_tx === 1'b0) begin
        mon_act = 1'b1;
        mon_cnt = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % DIV == DIV / 2) begin
        b = mon_cnt / DIV;
        if (b == 0) begin
          if (cur_tx !== 1'b0) frame_err++;
        end else if (b <= 8) begin
          mon_sh = {cur_tx, mon_sh[7:1]};
        end else begin
          if (cur_tx !== 1'b1) frame_err++;
          rx_q.push_back(mon_sh);
          mon_act = 1'b0;
        end
      end
    end
  endtask

  task automatic set_start(input int s, input logic v);
    case (s)
      1:       start_b = v;
      2:       start_c = v;
      default: start_a = v;
    endcase
  endtask

  task automatic pulse_start(input int s);
    set_start(s, 1'b1);
    step();
    set_start(s, 1'b0);
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (cur_done !== 1'b1 && cycles < budget) begin
      step();
      cycles++;
    end
    check("frame_done_seen", cur_done, 1'b1);
  endtask

  // Expected frame straight from the packet rules: SYNC, LE bytes per field, XOR of payload.
  task automatic model_frame(input int nf, input int fw);
    int bpf, v;
    logic [7:0] by, chk;
    bpf = (fw + 7) / 8;
    chk = 8'h00;
    exp_q.push_back(8'hA5);
    for (int k = 0; k < nf; k++) begin
      v = mvals[k] & ((1 << fw) - 1);
      for (int j = 0; j < bpf; j++) begin
        by = 8'((v >> (8 * j)) & 255);
        exp_q.push_back(by);
        chk = chk ^ by;
      end
    end
    exp_q.push_back(chk);
  endtask

  task automatic check_frame(input string name);
    logic [7:0] e, g;
    check({name, "_len"}, rx_q.size(), exp_q.size());
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      g = rx_q.pop_front();
      e = exp_q.pop_front();
      check({name, "_byte"}, g, e);
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic load_a(input logic [10:0] f0, input logic [10:0] f1);
    fields_a = {f1, f0};
    mvals[0] = int'(f0);
    mvals[1] = int'(f1);
  endtask

  initial begin
    int cyc, lows;
    logic [7:0] last;

    tbl[0] = '{f0: 11'h155, f1: 11'h2AA, chk: 8'hFC};
    tbl[1] = '{f0: 11'h000, f1: 11'h000, chk: 8'h00};
    tbl[2] = '{f0: 11'h7FF, f1: 11'h7FF, chk: 8'h00};
    tbl[3] = '{f0: 11'h123, f1: 11'h456, chk: 8'h70};
    tbl[4] = '{f0: 11'h001, f1: 11'h700, chk: 8'h06};

    n_chk = 0; n_fail = 0; drop_cnt = 0; done_cnt = 0; frame_err = 0;
    mon_act = 1'b0; mon_cnt = 0; mon_sh = '0; sel = 0;
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    fields_a = '0; fields_b = '0; fields_c = '0;

    // Reset state
    repeat (3) step();
    check("rst_tx_a", tx_a, 1'b1);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_done_a", done_a, 1'b0);
    check("rst_drop_a", drop_a, 1'b0);
    check("rst_tx_b", tx_b, 1'b1);
    check("rst_tx_c", tx_c, 1'b1);
    rst_n = 1'b1;
    repeat (3) step();

    // Basic frame with exact timing
    load_a(11'h155, 11'h2AA);
    exp_q = '{8'hA5, 8'h55, 8'h01, 8'hAA, 8'h02, 8'hFC};
    pulse_start(0);
    check("basic_tx_low", tx_a, 1'b0);
    check("basic_busy", busy_a, 1'b1);
    wait_done(2000, cyc);
    check("basic_cycles", cyc, 960);
    check("basic_done_busy", busy_a, 1'b0);
    check("basic_done_tx", tx_a, 1'b1);
    step();
    check("basic_done_pulse", done_a, 1'b0);
    check_frame("basic");

    // Table-driven vectors
    for (int i = 0; i < 5; i++) begin
      load_a(tbl[i].f0, tbl[i].f1);
      model_frame(2, 11);
      pulse_start(0);
      wait_done(2000, cyc);
      check("tbl_cycles", cyc, 960);
      last = (rx_q.size() > 0) ? rx_q[rx_q.size() - 1] : 8'hxx;
      check("tbl_chk", last, tbl[i].chk);
      check_frame("tbl");
      repeat (2) step();
    end

    // Snapshot: inputs change right after the accepted start
    load_a(11'h3C5, 11'h0A9);
    model_frame(2, 11);
    pulse_start(0);
    fields_a = ~fields_a;
    wait_done(2000, cyc);
    check_frame("snapshot");
    repeat (2) step();

    // Overlap: second start at cycle 100 is dropped
    load_a(11'h6B2, 11'h14D);
    model_frame(2, 11);
    drop_cnt = 0;
    done_cnt = 0;
    pulse_start(0);
    repeat (99) step();
    pulse_start(0);
    check("overlap_drop_pulse", drop_a, 1'b1);
    wait_done(2000, cyc);
    check("overlap_cycles", cyc, 860);
    check_frame("overlap");
    repeat (300) step();
    check("overlap_drop_cnt", drop_cnt, 1);
    check("overlap_done_cnt", done_cnt, 1);
    check("overlap_no_second", rx_q.size(), 0);
    check("overlap_idle", busy_a, 1'b0);

    // Back-to-back: start in the frame_done cycle
    drop_cnt = 0;
    load_a(11'h2F0, 11'h50F);
    model_frame(2, 11);
    pulse_start(0);
    wait_done(2000, cyc);
    load_a(11'h7E1, 11'h01E);
    model_frame(2, 11);
    pulse_start(0);
    check("b2b_tx_low", tx_a, 1'b0);
    check("b2b_busy", busy_a, 1'b1);
    check("b2b_no_drop", drop_cnt, 0);
    wait_done(2000, cyc);
    check("b2b_cycles", cyc, 960);
    check_frame("b2b");
    repeat (2) step();

    // Reset mid-frame (during byte 3)
    load_a(11'h3A3, 11'h5C5);
    pulse_start(0);
    repeat (500) step();
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_tx", tx_a, 1'b1);
    check("rstmid_busy", busy_a, 1'b0);
    repeat (3) step();
    rst_n = 1'b1;
    rx_q.delete();
    exp_q.delete();
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (tx_a !== 1'b1 || busy_a !== 1'b0) lows++;
    end
    check("rstmid_idle", lows, 0);
    check("rstmid_no_bytes", rx_q.size(), 0);
    load_a(11'h111, 11'h6EE);
    model_frame(2, 11);
    pulse_start(0);
    wait_done(2000, cyc);
    check("rstmid_cycles", cyc, 960);
    check_frame("rstmid");
    repeat (2) step();

    // Randomised frames against the model
    for (int r = 0; r < 6; r++) begin
      load_a(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)));
      model_frame(2, 11);
      pulse_start(0);
      wait_done(2000, cyc);
      check("rand_cycles", cyc, 960);
      check_frame("rand");
      repeat ($urandom_range(1, 4)) step();
    end

    // N_FIELDS=5, FIELD_W=4: one byte per field
    sel = 1;
    fields_b = 20'hFFFFF;
    exp_q = '{8'hA5, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F};
    pulse_start(1);
    wait_done(3000, cyc);
    check("w4_cycles", cyc, 1120);
    check_frame("w4");
    repeat (2) step();

    // FIELD_W=16: two full bytes per field
    sel = 2;
    fields_c = {16'h1234, 16'hBEEF};
    exp_q = '{8'hA5, 8'hEF, 8'hBE, 8'h34, 8'h12, 8'h77};
    pulse_start(2);
    wait_done(2000, cyc);
    check("w16_cycles", cyc, 960);
    check_frame("w16");
    repeat (2) step();
    mvals[0] = int'($urandom_range(0, 65535));
    mvals[1] = int'($urandom_range(0, 65535));
    fields_c = {16'(mvals[1]), 16'(mvals[0])};
    model_frame(2, 16);
    pulse_start(2);
    wait_done(2000, cyc);
    check_frame("w16_rand");
    repeat (2) step();

    check("framing_errors", frame_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
